// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - hex command parser for a UART byte stream with optional echo path
// Collects up to DIGITS hex characters, commits them on CR, flags malformed commands.
// Define UART_CMD_ECHO_EN to compile in the echo FIFO that feeds received bytes back to the UART.
module uart_cmd_parser #(
  parameter int DIGITS     = 4,
  parameter int ECHO_DEPTH = 4
) (
  input  logic                CLOCK_100,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [4*DIGITS-1:0] cmd_value,
  output logic                cmd_valid,
  output logic                cmd_error,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_busy,
  output logic                echo_ovf
);

  localparam int VW   = 4 * DIGITS;
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam logic [CNTW-1:0] DIGITS_C = CNTW'(DIGITS);
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIGITS,
    ST_ERROR
  } state_t;

  state_t          state_q;
  logic [VW-1:0]   acc_q;
  logic [VW-1:0]   cmd_value_q;
  logic [CNTW-1:0] count_q;
  logic            cmd_valid_q;
  logic            cmd_error_q;

  logic            is_hex;
  logic            is_cr;
  logic            is_skip;
  logic [3:0]      nibble;

  // Classify the received byte; letters map to 10-15 through their low nibble plus 9
  always_comb begin
    is_hex  = 1'b0;
    nibble  = 4'h0;
    is_cr   = (rx_data == CH_CR);
    is_skip = (rx_data == CH_LF) || (rx_data == CH_SP);
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_data[3:0] + 4'd9;
    end
  end

  // Parser FSM: accumulate digits, commit on CR, swallow everything after a bad byte until CR
  always_ff @(posedge CLOCK_100) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      cmd_value_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
      if (rx_valid && !is_skip) begin
        case (state_q)
          ST_IDLE: begin
            if (is_hex) begin
              acc_q   <= VW'(nibble);
              count_q <= CNTW'(1);
              state_q <= ST_DIGITS;
            end else if (!is_cr) begin
              state_q <= ST_ERROR;
            end
          end
          ST_DIGITS: begin
            if (is_hex) begin
              if (count_q < DIGITS_C) begin
                acc_q   <= (acc_q << 4) | VW'(nibble);
                count_q <= count_q + CNTW'(1);
              end else begin
                state_q <= ST_ERROR;
              end
            end else if (is_cr) begin
              cmd_value_q <= acc_q;
              cmd_valid_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_ERROR;
            end
          end
          ST_ERROR: begin
            if (is_cr) begin
              cmd_error_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_value = cmd_value_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_error = cmd_error_q;

`ifdef UART_CMD_ECHO_EN
  localparam int PW = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(ECHO_DEPTH);

  logic [7:0]    mem_q [ECHO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   fill_q;
  logic [7:0]    tx_data_q;
  logic          tx_send_q;
  logic          sent_d1_q;
  logic          guard_q;
  logic          echo_ovf_q;

  logic          full;
  logic          pop;
  logic          push;

  // Pop only toward an idle UART with no send outstanding; a pop frees room for a push when full
  always_comb begin
    full = (fill_q == DEPTH_C);
    pop  = (fill_q != '0) && !tx_busy && !guard_q;
    push = rx_valid && (!full || pop);
  end

  // Echo storage; occupancy lives in the pointers so the array itself needs no reset
  always_ff @(posedge CLOCK_100) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Echo control: pointers, send strobe, busy guard and sticky overflow flag
  always_ff @(posedge CLOCK_100) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      sent_d1_q  <= 1'b0;
      guard_q    <= 1'b0;
      echo_ovf_q <= 1'b0;
    end else begin
      tx_send_q <= pop;
      sent_d1_q <= tx_send_q;
      if (pop) begin
        tx_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        guard_q   <= 1'b1;
      end else if (guard_q && !tx_send_q && !sent_d1_q && !tx_busy) begin
        // the UART needs a cycle to raise tx_busy, so busy=0 right after a send is not trusted
        guard_q <= 1'b0;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (rx_valid && full && !pop) begin
        echo_ovf_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + (PW+1)'(1);
        2'b01:   fill_q <= fill_q - (PW+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign echo_ovf = echo_ovf_q;
`else
  logic        unused_tx_busy;
  logic [31:0] unused_echo_depth;

  assign unused_tx_busy    = tx_busy;
  assign unused_echo_depth = ECHO_DEPTH;

  assign tx_data  = 8'h00;
  assign tx_send  = 1'b0;
  assign echo_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int DIGITS     = 4;
  localparam int ECHO_DEPTH = 4;
  localparam int VW         = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_busy = 1'b0;
  logic [VW-1:0] cmd_value;
  logic          cmd_valid;
  logic          cmd_error;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          echo_ovf;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  bit echo_track = 1'b0;

  typedef struct {
    bit            is_err;
    logic [VW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    echo_q[$];
  logic [7:0]    line_q[$];
  logic [VW-1:0] last_val = '0;
  string         hex_chars = "0123456789abcdefABCDEF";

  uart_cmd_parser #(.DIGITS(DIGITS), .ECHO_DEPTH(ECHO_DEPTH)) dut (
    .CLOCK_100(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_value(cmd_value),
    .cmd_valid(cmd_valid),
    .cmd_error(cmd_error),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .echo_ovf(echo_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ref_is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic int ref_val(input logic [7:0] b);
    if (b <= "9") return int'(b) - int'("0");
    if (b <= "F") return int'(b) - int'("A") + 10;
    return int'(b) - int'("a") + 10;
  endfunction

  // Reference: judge the whole line at CR from its character content
  task automatic model_cr(input int at_cyc);
    int     n;
    bit     bad;
    longint v;
    exp_t   e;
    n = 0; bad = 0; v = 0;
    foreach (line_q[i]) begin
      if (line_q[i] != 8'h0A && line_q[i] != 8'h20) begin
        if (ref_is_hex(line_q[i])) begin
          n++;
          v = v * 16 + ref_val(line_q[i]);
        end else begin
          bad = 1;
        end
      end
    end
    line_q.delete();
    if (bad || n > DIGITS) begin
      e.is_err = 1; e.val = last_val; e.cyc = at_cyc;
      exp_q.push_back(e);
    end else if (n > 0) begin
      last_val = VW'(v);
      e.is_err = 0; e.val = last_val; e.cyc = at_cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  // Called at posedge+1; leaves at posedge+1 after the byte cycle and gap idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    if (b == 8'h0D) model_cr(cyc + 1);
    else line_q.push_back(b);
`ifdef UART_CMD_ECHO_EN
    if (echo_track) echo_q.push_back(b);
`endif
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = "5";
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    line_q.delete();
    echo_q.delete();
    exp_q.delete();
    last_val = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || echo_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (8) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0 || echo_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s pending_cmd=%0d pending_echo=%0d required 0 0",
               name, exp_q.size(), echo_q.size());
    end
  endtask

  function automatic int pick_gap();
`ifdef UART_CMD_ECHO_EN
    return $urandom_range(3, 5);
`else
    return $urandom_range(0, 3);
`endif
  endfunction

  // Monitor: every command pulse and every echo send is matched against the expectation queues
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] eb;
    if (!reset) begin
      if (cmd_valid || cmd_error) begin
        vectors++;
        if (cmd_valid && cmd_error) begin
          fails++;
          $display("FAIL both_pulses cycle=%0d valid=1 error=1 required exactly one", cyc);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse cycle=%0d valid=%0b error=%0b value=%0h required no pulse",
                   cyc, cmd_valid, cmd_error, cmd_value);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err != cmd_error || e.cyc != cyc || cmd_value !== e.val) begin
            fails++;
            $display("FAIL cmd_pulse got err=%0b cycle=%0d value=%0h required err=%0b cycle=%0d value=%0h",
                     cmd_error, cyc, cmd_value, e.is_err, e.cyc, e.val);
          end
        end
      end
`ifdef UART_CMD_ECHO_EN
      if (tx_send && echo_track) begin
        vectors++;
        if (echo_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_tx_send cycle=%0d tx_data=%0h required no send", cyc, tx_data);
        end else begin
          eb = echo_q.pop_front();
          if (tx_data !== eb) begin
            fails++;
            $display("FAIL echo_byte got=%0h required=%0h", tx_data, eb);
          end
        end
      end
`else
      if (tx_send || tx_data != 8'h00 || echo_ovf) begin
        vectors++;
        fails++;
        $display("FAIL echo_outputs_idle got send=%0b data=%0h ovf=%0b required 0 0 0",
                 tx_send, tx_data, echo_ovf);
      end
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails + 1);
    $fatal(1);
  end

  initial begin
    int         len;
    int         r;
    logic [7:0] b;

    @(posedge clk); #1;
    apply_reset();
    check("reset_cmd_value", 32'(cmd_value), 32'h0);
    check("reset_cmd_valid", 32'(cmd_valid), 32'h0);
    check("reset_cmd_error", 32'(cmd_error), 32'h0);
    check("reset_tx_send",   32'(tx_send),   32'h0);
    check("reset_tx_data",   32'(tx_data),   32'h0);
    check("reset_echo_ovf",  32'(echo_ovf),  32'h0);

    // back-to-back bytes, mixed case
    echo_track = 1'b0;
    send_str("1aF3", 0);
    send_byte(8'h0D, 0);
    wait_drain("b2b_1AF3");
    check("value_1AF3", 32'(cmd_value), 32'h1AF3);
`ifdef UART_CMD_ECHO_EN
    apply_reset();
    echo_track = 1'b1;
`endif

    send_byte("7", 3);
    send_byte(8'h0A, 3);
    send_byte(8'h0D, 3);
    send_byte(8'h0D, 3);
    wait_drain("lf_and_lone_cr");
    check("value_0007", 32'(cmd_value), 32'h0007);

    send_str("12345", 3);
    send_byte(8'h0D, 3);
    wait_drain("overlength");
    check("value_after_overlength", 32'(cmd_value), 32'h0007);

    send_byte("G", 3);
    send_byte(8'h0D, 3);
    wait_drain("bad_char");

    send_str("AB", 3);
    apply_reset();
    send_byte("C", 3);
    send_byte(8'h0D, 3);
    wait_drain("reset_mid_command");
    check("value_000C", 32'(cmd_value), 32'h000C);

`ifdef UART_CMD_ECHO_EN
    apply_reset();
    echo_track = 1'b1;
    tx_busy    = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 0);
    void'(echo_q.pop_back());
    void'(echo_q.pop_back());
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("echo_ovf_set", 32'(echo_ovf), 32'h1);
    tx_busy = 1'b0;
    wait_drain("echo_burst");
    check("echo_ovf_sticky", 32'(echo_ovf), 32'h1);

    apply_reset();
    echo_track = 1'b1;
    check("echo_ovf_reset", 32'(echo_ovf), 32'h0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 19);
    wait_drain("echo_spaced");
    apply_reset();
    echo_track = 1'b1;
`endif

    // randomized command lines
    for (int c = 0; c < 60; c++) begin
      len = $urandom_range(0, DIGITS + 1);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 70) begin
          b = hex_chars[$urandom_range(0, 21)];
        end else if (r < 85) begin
          b = ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h20;
        end else begin
          b = 8'($urandom);
          while (ref_is_hex(b) || b == 8'h0D || b == 8'h0A || b == 8'h20) b = 8'($urandom);
        end
        send_byte(b, pick_gap());
      end
      send_byte(8'h0D, pick_gap());
    end
    wait_drain("random");
    check("final_cmd_value", 32'(cmd_value), 32'(last_val));
    check("final_echo_ovf", 32'(echo_ovf), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
